nubus_master_sched: RTL
=======================

# nubus_master_sched

Round-robin scheduler that shares the single NuBus master port (the `cpu_*` request/response interface of the NuBus controller) between `NREQ` on-card requesters, such as the Wishbone-to-NuBus bridge and DMA engines. Each request is latched at grant and presented to the controller as exactly one master transaction. The block waits for the acknowledge and returns read data, or an error on watchdog expiry, to the owning requester. Locked sequences keep ownership across consecutive transactions.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..4.
- `WDT_W`, 10: watchdog width. A transaction is aborted after 2^WDT_W cycles in ISSUE.

Ports:
- `nub_clk` in, 1: NuBus clock (inverted `nub_clkn`).
- `nub_reset` in, 1: asynchronous, active-high reset.
- `req_valid` in, NREQ: per-requester request. Held high until that requester's `req_ready`.
- `req_addr` in, 32*NREQ: address, requester i at bits [32i+31:32i].
- `req_wdata` in, 32*NREQ: write data.
- `req_write` in, 4*NREQ: byte write enables. 0 means read.
- `req_lock` in, NREQ: keep ownership after this transaction completes.
- `req_ready` out, NREQ: one-cycle completion pulse to the owner.
- `req_err` out, 1: qualifies `req_ready`. 1 means watchdog abort.
- `req_rdata` out, 32: registered read data, valid with `req_ready`.
- `cpu_valid` out, 1: master transaction request.
- `cpu_addr` out, 32: latched address.
- `cpu_wdata` out, 32: latched write data.
- `cpu_write` out, 4: latched byte enables.
- `cpu_lock` out, 1: locked transfer.
- `cpu_ready` in, 1: controller completion (ACK seen, START released).
- `cpu_rdata` in, 32: controller read data.
- `owner` out, 2: index of the current or last owner, for debug.

## Operation
- States: IDLE, ISSUE, GAP, LOCKHOLD.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, searching upward with wrap.
  - Latch that requester's addr, wdata, write and lock into the `cpu_*` registers. Set `owner`.
  - Go to ISSUE and clear the watchdog.
- ISSUE:
  - `cpu_valid`=1. The watchdog increments every cycle.
  - On `cpu_ready`: register `cpu_rdata` into `req_rdata`, pulse `req_ready[owner]` with `req_err`=0, go to GAP.
  - On watchdog terminal count without `cpu_ready`: pulse `req_ready[owner]` with `req_err`=1, `req_rdata`=32'hFFFF_FFFF, go to GAP.
  - If `cpu_ready` and terminal count occur in the same cycle, `cpu_ready` wins.
- GAP:
  - One cycle with `cpu_valid`=0, which guarantees the controller sees a deasserted request between transactions.
  - `cpu_ready` is ignored in this state.
  - If the latched lock is 1 and the abort flag is 0, go to LOCKHOLD. Otherwise set `rr_ptr`=owner+1 (mod NREQ), clear `cpu_lock`, go to IDLE.
- LOCKHOLD:
  - `cpu_lock` stays 1. Other requesters are not served.
  - If `req_valid[owner]` is high: relatch the payload from owner, go to ISSUE.
  - Else if `req_lock[owner]`=0: release and advance `rr_ptr` as in GAP, go to IDLE.
  - A watchdog abort always ends the lock.
- Widths:
  - Watchdog is WDT_W bits. Terminal count is all ones.
  - `rr_ptr` and `owner` are 2 bits. Values ≥ NREQ never occur.

## Timing
- Reset values: state=IDLE, `cpu_valid`=0, `cpu_lock`=0, `cpu_addr`/`cpu_wdata`=0, `cpu_write`=0, `req_ready`=0, `req_err`=0, `req_rdata`=0, `rr_ptr`=0, `owner`=0.
- Asserting reset mid-transaction drops `cpu_valid` asynchronously. No `req_ready` is produced for the aborted request.
- Grant latency: `req_valid` sampled high in IDLE gives `cpu_valid`=1 on the next edge.
- Completion: `cpu_ready` high at edge N gives `req_ready`/`req_rdata` at N+1 (registered) and `cpu_valid`=0 at N+1.
- Minimum spacing is 1 GAP cycle. The earliest next `cpu_valid` is N+3 for unlocked traffic and N+3 for locked traffic.
- Each request produces exactly one `req_ready` pulse.
- Requesters must hold `req_valid` and payload stable only until grant. A `req_valid` dropped before grant is never served.
- Fairness: with all requesters valid, the grant order is strictly 0,1,…,NREQ-1,0… Starvation is bounded by (NREQ-1) transactions plus any lock sequences.

## Structure
- Shared package `nubus_pkg`: state enum (IDLE/ISSUE/GAP/LOCKHOLD), `ERR_RDATA`=32'hFFFF_FFFF, and the requester-index width constant.
- Sub-module `nubus_rr_pick`: combinational round-robin priority pick, taking `req_valid` and `rr_ptr` and producing the grant index and an any-valid flag.
- The FSM, payload registers and watchdog live in the top module.

## Test plan
- Single read: req0 reads 32'hF900_0000, and `cpu_ready` is returned 3 cycles after `cpu_valid` with `cpu_rdata`=32'h1234_5678. Expect one `req_ready[0]` pulse, `req_rdata`=32'h1234_5678, `req_err`=0, `cpu_valid` low on the following cycle.
- Round-robin: req0 and req1 both held valid for 4 transactions. Expect grant order 0,1,0,1 and a GAP cycle (`cpu_valid`=0) between every pair.
- Lock: req1 issues two writes with `req_lock`=1, while req0 is valid throughout. Expect `cpu_lock`=1 across both writes, req0 served only after req1 drops `req_lock`, and `rr_ptr` then equal to 0.
- Watchdog: WDT_W=4 and `cpu_ready` never asserted. Expect `req_ready[0]` with `req_err`=1 and `req_rdata`=32'hFFFF_FFFF after 16 cycles in ISSUE. A locked owner loses the lock.
- Simultaneous terminal count and `cpu_ready`: expect `req_err`=0 and the real data returned.
- Reset at cycle 2 of ISSUE: expect `cpu_valid`=0 immediately with no clock edge, no `req_ready` pulse, and a fresh grant from `rr_ptr`=0 after reset release.

Source files
------------

// File: rtl/nubus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nubus_pkg                                                            |
// | Shared types and constants for the NuBus master-port scheduler.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nubus_pkg;

    localparam int          IDX_W     = 2;
    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_GAP      = 2'd2,
        S_LOCKHOLD = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nubus_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nubus_rr_pick                                                        |
// | Combinational round-robin pick: first valid requester at or after   |
// | rr_ptr, searching upward with wrap. Revision: 1.0                    |
// +----------------------------------------------------------------------+
module nubus_rr_pick
    import nubus_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);

    logic [IDX_W:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        any_valid = |req_valid;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NREQ)) begin
                cand = cand - (IDX_W + 1)'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && cand == (IDX_W + 1)'(i)) begin
                    grant = IDX_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nubus_master_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nubus_master_sched                                                   |
// | Round-robin sharing of the NuBus controller master port between      |
// | NREQ requesters, with locked sequences and a watchdog. Revision: 1.0 |
// +----------------------------------------------------------------------+
module nubus_master_sched
    import nubus_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WDT_W = 10
) (
    input  logic                 nub_clk,
    input  logic                 nub_reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    input  logic [4*NREQ-1:0]    req_write,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic                 req_err,
    output logic [31:0]          req_rdata,
    output logic                 cpu_valid,
    output logic [31:0]          cpu_addr,
    output logic [31:0]          cpu_wdata,
    output logic [3:0]           cpu_write,
    output logic                 cpu_lock,
    input  logic                 cpu_ready,
    input  logic [31:0]          cpu_rdata,
    output logic [1:0]           owner
);

    state_t             r_state;
    logic [WDT_W-1:0]   r_wdt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_abort;

    logic [IDX_W-1:0]   w_grant;
    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic               w_sel_valid;
    logic               w_sel_lock;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [3:0]         w_sel_write;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [NREQ-1:0]    w_owner_hot;

    nubus_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .any_valid (w_any)
    );

    // While a lock is held only the owner may be relatched.
    assign w_sel       = (r_state == S_LOCKHOLD) ? owner : w_grant;
    assign w_next_ptr  = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);
    assign w_owner_hot = NREQ'(4'b0001 << owner);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_lock  = req_lock[i];
                w_sel_addr  = req_addr[32*i +: 32];
                w_sel_wdata = req_wdata[32*i +: 32];
                w_sel_write = req_write[4*i +: 4];
            end
        end
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            r_state   <= S_IDLE;
            r_wdt     <= '0;
            r_rr_ptr  <= '0;
            r_abort   <= 1'b0;
            owner     <= '0;
            cpu_valid <= 1'b0;
            cpu_addr  <= '0;
            cpu_wdata <= '0;
            cpu_write <= '0;
            cpu_lock  <= 1'b0;
            req_ready <= '0;
            req_err   <= 1'b0;
            req_rdata <= '0;
        end else begin
            req_ready <= '0;
            req_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        owner     <= w_grant;
                        cpu_addr  <= w_sel_addr;
                        cpu_wdata <= w_sel_wdata;
                        cpu_write <= w_sel_write;
                        cpu_lock  <= w_sel_lock;
                        cpu_valid <= 1'b1;
                        r_wdt     <= '0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdt <= r_wdt + WDT_W'(1);
                    // A real acknowledge takes priority over a coincident timeout.
                    if (cpu_ready) begin
                        req_rdata <= cpu_rdata;
                        req_ready <= w_owner_hot;
                        r_abort   <= 1'b0;
                        cpu_valid <= 1'b0;
                        r_state   <= S_GAP;
                    end else if (&r_wdt) begin
                        req_rdata <= ERR_RDATA;
                        req_ready <= w_owner_hot;
                        req_err   <= 1'b1;
                        r_abort   <= 1'b1;
                        cpu_valid <= 1'b0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cpu_lock && !r_abort) begin
                        r_state <= S_LOCKHOLD;
                    end else begin
                        r_rr_ptr <= w_next_ptr;
                        cpu_lock <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_LOCKHOLD: begin
                    if (w_sel_valid) begin
                        cpu_addr  <= w_sel_addr;
                        cpu_wdata <= w_sel_wdata;
                        cpu_write <= w_sel_write;
                        cpu_lock  <= w_sel_lock;
                        cpu_valid <= 1'b1;
                        r_wdt     <= '0;
                        r_state   <= S_ISSUE;
                    end else if (!w_sel_lock) begin
                        r_rr_ptr <= w_next_ptr;
                        cpu_lock <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
